sync_fifo_hs: RTL and testbench

- Parametrised single-clock FIFO with a valid/ready handshake on both sides; generation successor to the dual-clock 8-bit FIFO.
- Adds:
  - generic data width and depth
  - first-word-fall-through output
  - live occupancy count
  - programmable almost-full/almost-empty flags
  - synchronous flush
  - high-water-mark register
- Used inside a single clock domain for rate smoothing between pipeline stages and for occupancy monitoring.

---
 rtl/sync_fifo_hs.sv | 110 +++++++++++
 tb/tb_sync_fifo_hs.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_hs.sv
// Single-clock FWFT FIFO with valid/ready handshakes, occupancy count,
// registered almost-full/almost-empty flags, synchronous flush and high-water mark.
module sync_fifo_hs #(
    parameter  int DATA_W    = 8,
    parameter  int DEPTH     = 8,
    parameter  int AF_THRESH = DEPTH - 2,
    parameter  int AE_THRESH = 1,
    localparam int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic              clkin,
    input  logic              rstin,
    input  logic              flush,
    input  logic              ivalid,
    output logic              iready,
    input  logic [DATA_W-1:0] din,
    output logic              ovalid,
    input  logic              oready,
    output logic [DATA_W-1:0] dout,
    output logic [CNT_W-1:0]  count,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CNT_W-1:0]  hwm
);

    localparam int PTR_W = $clog2(DEPTH);

    if (DATA_W < 1) begin : g_bad_width
        $error("sync_fifo_hs: DATA_W must be >= 1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_hs: DEPTH must be a power of two >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("sync_fifo_hs: AF_THRESH must be in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_hs: AE_THRESH must be in 0..DEPTH-1");
    end

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  hwm_q, hwm_d;
    logic              af_q, af_d;
    logic              ae_q, ae_d;
    logic              wr_en, rd_en;

    // Handshake readiness is derived purely from registered occupancy.
    assign iready       = (count_q != CNT_W'(DEPTH));
    assign ovalid       = (count_q != '0);
    assign dout         = mem_q[rd_ptr_q];
    assign count        = count_q;
    assign hwm          = hwm_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;

    assign wr_en = ivalid && iready && !flush;
    assign rd_en = ovalid && oready && !flush;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        hwm_d = (count_d > hwm_q) ? count_d : hwm_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            hwm_d    = '0;
        end
        // Flags track the next-state count so they move on the same edge as count.
        af_d = (count_d >= CNT_W'(AF_THRESH));
        ae_d = (count_d <= CNT_W'(AE_THRESH));
    end

    always_ff @(posedge clkin) begin
        mem_q <= mem_d;
        if (rstin) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hwm_q    <= '0;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hwm_q    <= hwm_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
        end
    end

endmodule

// File: tb/tb_sync_fifo_hs.sv
// Directed and scoreboard bench for sync_fifo_hs with DATA_W=8, DEPTH=8,
// AF_THRESH=6, AE_THRESH=1.
module tb_sync_fifo_hs;

    logic       clk;
    logic       rstin;
    logic       flush;
    logic       ivalid;
    logic       iready;
    logic [7:0] din;
    logic       ovalid;
    logic       oready;
    logic [7:0] dout;
    logic [3:0] count;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] hwm;

    int checks = 0;
    int errors = 0;

    sync_fifo_hs #(
        .DATA_W   (8),
        .DEPTH    (8),
        .AF_THRESH(6),
        .AE_THRESH(1)
    ) dut (
        .clkin       (clk),
        .rstin       (rstin),
        .flush       (flush),
        .ivalid      (ivalid),
        .iready      (iready),
        .din         (din),
        .ovalid      (ovalid),
        .oready      (oready),
        .dout        (dout),
        .count       (count),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .hwm         (hwm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush  = 1'b0;
        ivalid = 1'b0;
        oready = 1'b0;
        din    = 8'h00;
    endtask

    task automatic test_reset();
        rstin = 1'b1;
        idle_inputs();
        repeat (3) step();
        rstin = 1'b0;
        step();
        checks++; if (iready !== 1'b1) begin errors++; $display("FAIL reset_iready got=%b exp=1", iready); end
        checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL reset_ovalid got=%b exp=0", ovalid); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_ae got=%b exp=1", almost_empty); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_af got=%b exp=0", almost_full); end
        checks++; if (hwm !== 4'd0) begin errors++; $display("FAIL reset_hwm got=%0d exp=0", hwm); end
    endtask

    task automatic test_basic();
        ivalid = 1'b1;
        din    = 8'h01;
        step();
        checks++; if (ovalid !== 1'b1) begin errors++; $display("FAIL basic_ovalid_latency got=%b exp=1", ovalid); end
        checks++; if (dout !== 8'h01) begin errors++; $display("FAIL basic_fwft_dout got=%h exp=01", dout); end
        din = 8'h02;
        step();
        din = 8'h03;
        step();
        ivalid = 1'b0;
        checks++; if (count !== 4'd3) begin errors++; $display("FAIL basic_count got=%0d exp=3", count); end
        checks++; if (almost_empty !== 1'b0) begin errors++; $display("FAIL basic_ae got=%b exp=0", almost_empty); end
        checks++; if (dout !== 8'h01) begin errors++; $display("FAIL basic_dout_hold got=%h exp=01", dout); end
        oready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            checks++; if (dout !== 8'(i)) begin errors++; $display("FAIL basic_read%0d got=%h exp=%h", i, dout, 8'(i)); end
            step();
        end
        oready = 1'b0;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL basic_drain_count got=%0d exp=0", count); end
        checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL basic_drain_ovalid got=%b exp=0", ovalid); end
        checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL basic_drain_ae got=%b exp=1", almost_empty); end
    endtask

    task automatic test_full();
        int nxt;
        nxt    = 1;
        ivalid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            din = 8'(nxt);
            if (nxt <= 8) begin
                checks++; if (iready !== 1'b1) begin errors++; $display("FAIL full_iready_w%0d got=%b exp=1", nxt, iready); end
            end else begin
                checks++; if (iready !== 1'b0) begin errors++; $display("FAIL full_iready_blocked got=%b exp=0", iready); end
            end
            step();
            if (nxt <= 8) nxt++;
            if (nxt == 6) begin
                checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL full_af_at5 got=%b exp=0", almost_full); end
            end
            if (nxt == 7 && c == 5) begin
                checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL full_af_at6 got=%b exp=1", almost_full); end
            end
        end
        ivalid = 1'b0;
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_count got=%0d exp=8", count); end
        checks++; if (iready !== 1'b0) begin errors++; $display("FAIL full_iready got=%b exp=0", iready); end
        checks++; if (hwm !== 4'd8) begin errors++; $display("FAIL full_hwm got=%0d exp=8", hwm); end
        checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL full_af got=%b exp=1", almost_full); end
        oready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            checks++; if (dout !== 8'(i)) begin errors++; $display("FAIL full_read%0d got=%h exp=%h", i, dout, 8'(i)); end
            step();
        end
        oready = 1'b0;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL full_drain_count got=%0d exp=0", count); end
        checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL full_drain_ovalid got=%b exp=0", ovalid); end
        checks++; if (hwm !== 4'd8) begin errors++; $display("FAIL full_drain_hwm got=%0d exp=8", hwm); end
    endtask

    task automatic test_full_concurrent();
        int nxt_w;
        int nxt_r;
        ivalid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            din = 8'(i);
            step();
        end
        nxt_w = 9;
        nxt_r = 1;
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL conc_fill_count got=%0d exp=8", count); end
        din    = 8'(nxt_w);
        oready = 1'b1;
        checks++; if (iready !== 1'b0) begin errors++; $display("FAIL conc_full_iready got=%b exp=0", iready); end
        checks++; if (dout !== 8'h01) begin errors++; $display("FAIL conc_full_dout got=%h exp=01", dout); end
        step();
        nxt_r++;
        checks++; if (count !== 4'd7) begin errors++; $display("FAIL conc_full_count got=%0d exp=7", count); end
        for (int c = 0; c < 21; c++) begin
            din = 8'(nxt_w);
            checks++; if (iready !== 1'b1) begin errors++; $display("FAIL conc_iready_c%0d got=%b exp=1", c, iready); end
            checks++; if (dout !== 8'(nxt_r)) begin errors++; $display("FAIL conc_dout_c%0d got=%h exp=%h", c, dout, 8'(nxt_r)); end
            step();
            nxt_w++;
            nxt_r++;
            checks++; if (count !== 4'd7) begin errors++; $display("FAIL conc_count_c%0d got=%0d exp=7", c, count); end
        end
        ivalid = 1'b0;
        for (int c = 0; c < 7; c++) begin
            checks++; if (dout !== 8'(nxt_r)) begin errors++; $display("FAIL conc_drain%0d got=%h exp=%h", c, dout, 8'(nxt_r)); end
            step();
            nxt_r++;
        end
        oready = 1'b0;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL conc_drain_count got=%0d exp=0", count); end
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        int         max_sz;
        logic [7:0] wdata;
        logic       exp_ir, exp_ov, wr, rd;
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (hwm !== 4'd0) begin errors++; $display("FAIL rand_flush_hwm got=%0d exp=0", hwm); end
        max_sz = 0;
        wdata  = 8'h00;
        for (int c = 0; c < 200; c++) begin
            ivalid = 1'($urandom_range(0, 1));
            oready = 1'($urandom_range(0, 1));
            din    = wdata;
            exp_ir = (q.size() < 8);
            exp_ov = (q.size() > 0);
            checks++; if (iready !== exp_ir) begin errors++; $display("FAIL rand_iready_c%0d got=%b exp=%b", c, iready, exp_ir); end
            checks++; if (ovalid !== exp_ov) begin errors++; $display("FAIL rand_ovalid_c%0d got=%b exp=%b", c, ovalid, exp_ov); end
            if (exp_ov) begin
                checks++; if (dout !== q[0]) begin errors++; $display("FAIL rand_dout_c%0d got=%h exp=%h", c, dout, q[0]); end
            end
            wr = ivalid && exp_ir;
            rd = oready && exp_ov;
            step();
            if (rd) void'(q.pop_front());
            if (wr) begin
                q.push_back(wdata);
                wdata++;
            end
            if (q.size() > max_sz) max_sz = q.size();
            checks++; if (count !== 4'(q.size())) begin errors++; $display("FAIL rand_count_c%0d got=%0d exp=%0d", c, count, q.size()); end
            checks++; if (hwm !== 4'(max_sz)) begin errors++; $display("FAIL rand_hwm_c%0d got=%0d exp=%0d", c, hwm, max_sz); end
        end
        idle_inputs();
    endtask

    task automatic test_flush_reset(input bit use_reset);
        string tag;
        tag = use_reset ? "rst" : "flush";
        flush = 1'b1;
        step();
        flush  = 1'b0;
        ivalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            din = 8'hA0 + 8'(i);
            step();
        end
        checks++; if (count !== 4'd5) begin errors++; $display("FAIL %s_pre_count got=%0d exp=5", tag, count); end
        din    = 8'hEE;
        oready = 1'b1;
        if (use_reset) rstin = 1'b1;
        else flush = 1'b1;
        step();
        rstin  = 1'b0;
        flush  = 1'b0;
        ivalid = 1'b0;
        oready = 1'b0;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL %s_count got=%0d exp=0", tag, count); end
        checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL %s_ovalid got=%b exp=0", tag, ovalid); end
        checks++; if (hwm !== 4'd0) begin errors++; $display("FAIL %s_hwm got=%0d exp=0", tag, hwm); end
        checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL %s_ae got=%b exp=1", tag, almost_empty); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL %s_af got=%b exp=0", tag, almost_full); end
        checks++; if (iready !== 1'b1) begin errors++; $display("FAIL %s_iready got=%b exp=1", tag, iready); end
        ivalid = 1'b1;
        din    = 8'h77;
        step();
        ivalid = 1'b0;
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL %s_after_count got=%0d exp=1", tag, count); end
        checks++; if (dout !== 8'h77) begin errors++; $display("FAIL %s_after_dout got=%h exp=77", tag, dout); end
        checks++; if (hwm !== 4'd1) begin errors++; $display("FAIL %s_after_hwm got=%0d exp=1", tag, hwm); end
    endtask

    initial begin
        rstin = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_full();
        test_full_concurrent();
        test_random();
        test_flush_reset(1'b0);
        test_flush_reset(1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
